dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory port. It is the slave end of a valid/ready request/response protocol.
- Accepts one load or store at a time, waits a programmable number of cycles to model the access delay, then returns read data or a write acknowledgement.
- Sits behind the EXMEM stage and replaces the single-cycle Data_Memory once the pipeline gains a memory-stall path.

---
 rtl/dmem_responder.sv | 184 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the data-memory valid/ready port. Accepts one
// load or store at a time, waits LATENCY cycles, then returns read data or a
// store acknowledgement held until the requester takes it.
//
// Parameters:
//   DEPTH   - number of 32-bit words (power of 2)
//   LATENCY - cycles from request accept to rsp_valid_o (1..15)
//
// Ports:
//   clk_i, rst_i                    clock, async active-low reset
//   req_valid_i / req_ready_o       request handshake
//   req_we_i, req_addr_i,
//   req_wdata_i, req_be_i           request payload (latched at accept)
//   rsp_valid_o / rsp_ready_i       response handshake
//   rsp_rdata_o, rsp_err_o          response payload
//   busy_o                          a request is in flight
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   defined   - req_addr_i[1:0] != 0 skips the access and responds with
//               rsp_err_o = 1, rsp_rdata_o = 0
//   undefined - req_addr_i[1:0] ignored, rsp_err_o always 0
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_we, w_we_nxt;
  logic [AW-1:0]   r_idx, w_idx_nxt;
  logic [31:0]     r_wdata, w_wdata_nxt;
  logic [3:0]      r_be, w_be_nxt;
  logic            r_req_ready, w_req_ready_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]     r_rdata, w_rdata_nxt;
  logic            r_err, w_err_nxt;
  logic            r_busy, w_busy_nxt;

  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     w_rd_word;
  logic            w_access;
  logic            w_wr_en;
  logic            w_misalign;
  logic            w_unused_addr;

  // Misalignment detection: byte offset is only kept when errors are reported
`ifdef DMEM_MISALIGN_ERR_EN
  logic [1:0] r_off;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_off <= 2'b00;
    else if (r_state == S_IDLE && req_valid_i && r_req_ready)
      r_off <= req_addr_i[1:0];
  end

  assign w_misalign    = |r_off;
  assign w_unused_addr = &{1'b0, req_addr_i[31:AW+2]};
`else
  assign w_misalign    = 1'b0;
  assign w_unused_addr = &{1'b0, req_addr_i[31:AW+2], req_addr_i[1:0]};
`endif

  assign w_rd_word = r_mem[r_idx];
  assign w_wr_en   = w_access && r_we && !w_misalign;

  // State and request/response registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_we        <= w_we_nxt;
      r_idx       <= w_idx_nxt;
      r_wdata     <= w_wdata_nxt;
      r_be        <= w_be_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err       <= w_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Storage is not reset; a reset in WAIT moves state to IDLE before any access edge
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (r_be[k])
          r_mem[r_idx][8*k +: 8] <= r_wdata[8*k +: 8];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_we_nxt        = r_we;
    w_idx_nxt       = r_idx;
    w_wdata_nxt     = r_wdata;
    w_be_nxt        = r_be;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rdata_nxt     = r_rdata;
    w_err_nxt       = r_err;
    w_access        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (req_valid_i && r_req_ready) begin
          w_we_nxt        = req_we_i;
          w_idx_nxt       = req_addr_i[AW+1:2];
          w_wdata_nxt     = req_wdata_i;
          w_be_nxt        = req_be_i;
          w_cnt_nxt       = CW'(LATENCY - 1);
          w_req_ready_nxt = 1'b0;
          w_state_nxt     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_access        = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_err_nxt       = w_misalign;
          w_rdata_nxt     = (r_we || w_misalign) ? 32'h0 : w_rd_word;
          w_state_nxt     = S_RESP;
        end
      end
      S_RESP: begin
        if (r_rsp_valid && rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH = 1024, LATENCY = 3).
module tb_dmem_responder;

  localparam int unsigned LAT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_i = ~clk_i;

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Present a request at a negedge and return at the negedge after the accept edge
  task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int k = 0;
    while (!req_ready_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_be_i    = be;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Count cycles from accept until rsp_valid_o, bounded
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check({tag, "_vld_clr"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_rdy_set"}, 32'(req_ready_o), 32'd1);
    check({tag, "_idle"},    32'(busy_o),      32'd0);
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    issue(tag, we, addr, wdata, be);
    check({tag, "_busy"},    32'(busy_o),      32'd1);
    check({tag, "_rdy_low"}, 32'(req_ready_o), 32'd0);
    wait_rsp(lat);
    check({tag, "_lat"},   32'(lat),       32'(LAT));
    check({tag, "_rdata"}, rsp_rdata_o,    exp_rdata);
    check({tag, "_err"},   32'(rsp_err_o), 32'(exp_err));
    handshake(tag);
  endtask

  initial begin
    int  lat;
    logic seen;

    rst_i       = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_be_i    = '0;
    rsp_ready_i = 1'b0;

    // Reset held for 3 cycles: every output low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rst_outs",
            {27'd0, req_ready_o, rsp_valid_o, rsp_err_o, busy_o, |rsp_rdata_o}, 32'd0);
    end
    rst_i = 1'b1;
    #1;
    check("rel_rdy_pre", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    check("rel_rdy_post", 32'(req_ready_o), 32'd1);
    check("rel_busy",     32'(busy_o),      32'd0);

    // Store then load
    txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    txn("ld10", 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);

    // Byte enables
    txn("st20",   1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
    txn("st20be", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0);
    txn("ld20",   1'b0, 32'h20, 32'h0,        4'hF, 32'h11BB33DD, 1'b0);

    // Wrap: 0x1010 aliases 0x10; hold response off for 5 cycles while
    // wiggling request inputs, which must be ignored
    issue("wrap", 1'b0, 32'h1010, 32'h0, 4'h0);
    wait_rsp(lat);
    check("wrap_lat", 32'(lat), 32'(LAT));
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 32'h10;
    req_wdata_i = 32'h0;
    req_be_i    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("bp_vld",   32'(rsp_valid_o), 32'd1);
      check("bp_rdata", rsp_rdata_o,      32'hDEADBEEF);
      check("bp_rdy",   32'(req_ready_o), 32'd0);
    end
    req_valid_i = 1'b0;
    handshake("wrap");

    // Zero byte-enable store completes, memory untouched
    txn("st10be0", 1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
    txn("ld10b",   1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Reset one cycle after accepting a store: dropped, no write
    txn("st40", 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    issue("st40x", 1'b1, 32'h40, 32'h0BADBEEF, 4'hF);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_busy", 32'(busy_o),      32'd0);
    check("mid_rst_vld",  32'(rsp_valid_o), 32'd0);
    rst_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      seen = seen | rsp_valid_o;
    end
    check("mid_rst_norsp", 32'(seen), 32'd0);
    txn("ld40", 1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

    // Misaligned store to 0x42
`ifdef DMEM_MISALIGN_ERR_EN
    txn("st42", 1'b1, 32'h42, 32'h12345678, 4'hF, 32'h0, 1'b1);
    txn("ld40m", 1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
`else
    txn("st42", 1'b1, 32'h42, 32'h12345678, 4'hF, 32'h0, 1'b0);
    txn("ld40m", 1'b0, 32'h40, 32'h0, 4'h0, 32'h12345678, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
